// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, flag bit positions, FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Flag register layout {N,Z,C,V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Arithmetic ops own all four flags; logical ops leave V alone
    function automatic logic op_is_arith(input logic [3:0] op);
        case (op)
            OP_SUB, OP_RSB, OP_ADD, OP_ADC,
            OP_SBC, OP_RSC, OP_CMP, OP_CMN: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Compare/test ops always write flags regardless of setflags
    function automatic logic op_is_compare(input logic [3:0] op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-requester round-robin grant: the favoured side wins if it asks,
// otherwise the other side gets it. Next pointer favours the loser.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       ptr_nxt_o
);

    // Grant vector from request pair and priority pointer
    always_comb begin
        gnt_o = '0;
        if (req_i[ptr_i]) begin
            gnt_o[ptr_i] = 1'b1;
        end else if (req_i[~ptr_i]) begin
            gnt_o[~ptr_i] = 1'b1;
        end
    end

    // Pointer moves to the non-granted requester; holds when nothing granted
    always_comb begin
        ptr_nxt_o = ptr_i;
        if (gnt_o[0]) begin
            ptr_nxt_o = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_nxt_o = 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU, one operation
// at a time (IDLE -> EXEC -> RESP), and maintains the {N,Z,C,V} flag register.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req0_setflags,
    input  logic        req0_shc,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    input  logic        req1_setflags,
    input  logic        req1_shc,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [3:0]  alu_control,
    output logic        alu_carry_in,
    output logic        alu_shifter_carry,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  flags
);

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d, ptr_nxt;
    logic [1:0]  gnt;
    logic        accept;
    logic [31:0] a_q, b_q;
    logic [3:0]  op_q;
    logic        sf_q, shc_q, id_q;
    logic [31:0] rsp_result_q;
    logic [3:0]  rsp_flags_q;
    logic        rsp_id_q;
    logic [3:0]  flags_q, flags_d;

    rr_arb2 u_arb (
        .req_i     ({req1_valid, req0_valid}),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .ptr_nxt_o (ptr_nxt)
    );

    assign accept = (state_q == ST_IDLE) && (gnt != 2'b00);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: one accept, one execute cycle, then hold response until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Outputs: accept pulse (forced low in reset) and ALU drive only while executing
    always_comb begin
        req0_ready        = accept && gnt[0] && !reset;
        req1_ready        = accept && gnt[1] && !reset;
        alu_srca          = '0;
        alu_srcb          = '0;
        alu_control       = '0;
        alu_carry_in      = 1'b0;
        alu_shifter_carry = 1'b0;
        if (state_q == ST_EXEC) begin
            alu_srca          = a_q;
            alu_srcb          = b_q;
            alu_control       = op_q;
            alu_carry_in      = flags_q[FLAG_C];
            alu_shifter_carry = shc_q;
        end
    end

    // Next pointer and flag register values
    always_comb begin
        ptr_d   = accept ? ptr_nxt : ptr_q;
        flags_d = flags_q;
        if (state_q == ST_EXEC && (sf_q || op_is_compare(op_q))) begin
            if (op_is_arith(op_q)) flags_d = alu_flags;
            else                   flags_d = {alu_flags[3:1], flags_q[FLAG_V]};
        end
    end

    // Pointer, flags, operand latch and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= PRIO_INIT;
            flags_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            sf_q         <= 1'b0;
            shc_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            flags_q <= flags_d;
            if (accept) begin
                a_q   <= gnt[1] ? req1_a        : req0_a;
                b_q   <= gnt[1] ? req1_b        : req0_b;
                op_q  <= gnt[1] ? req1_op       : req0_op;
                sf_q  <= gnt[1] ? req1_setflags : req0_setflags;
                shc_q <= gnt[1] ? req1_shc      : req0_shc;
                id_q  <= gnt[1];
            end
            if (state_q == ST_EXEC) begin
                rsp_result_q <= alu_result;
                rsp_flags_q  <= alu_flags;
                rsp_id_q     <= id_q;
            end
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU stub and a
// transaction-level reference model of grants and the flag register.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        req0_setflags, req1_setflags, req0_shc, req1_shc;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_control, alu_flags;
    logic        alu_carry_in, alu_shifter_carry;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags, flags;

    int checks = 0;
    int errors = 0;

    logic       ptr_m;
    logic [3:0] flags_m;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_setflags(req0_setflags), .req0_shc(req0_shc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_setflags(req1_setflags), .req1_shc(req1_shc),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_control(alu_control),
        .alu_carry_in(alu_carry_in), .alu_shifter_carry(alu_shifter_carry),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags(flags)
    );

    // {V, C, result} of x + y + ci
    function automatic logic [33:0] addf(input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, y} + {32'b0, ci};
        return {(x[31] == y[31]) && (s[31] != x[31]), s[32], s[31:0]};
    endfunction

    // Behavioural ALU: returns {N,Z,C,V, result}
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op, input logic cin, input logic shc);
        logic [33:0] t;
        logic [31:0] r;
        logic        c, v;
        t = '0;
        case (op)
            4'h2, 4'hA: t = addf(a, ~b, 1'b1);
            4'h3:       t = addf(b, ~a, 1'b1);
            4'h4, 4'hB: t = addf(a, b, 1'b0);
            4'h5:       t = addf(a, b, cin);
            4'h6:       t = addf(a, ~b, cin);
            4'h7:       t = addf(b, ~a, cin);
            4'h0, 4'h8: t = {1'b0, shc, a & b};
            4'h1, 4'h9: t = {1'b0, shc, a ^ b};
            4'hC:       t = {1'b0, shc, a | b};
            4'hD:       t = {1'b0, shc, b};
            4'hE:       t = {1'b0, shc, a & ~b};
            default:    t = {1'b0, shc, ~b};
        endcase
        r = t[31:0];
        c = t[32];
        v = t[33];
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic bit is_arith(input logic [3:0] op);
        return (op >= 4'h2 && op <= 4'h7) || op == 4'hA || op == 4'hB;
    endfunction

    // Architectural flag update rule applied to the model after an operation
    function automatic logic [3:0] next_flags(input logic [3:0] old, input logic [3:0] f,
                                              input logic [3:0] op, input logic sf);
        if (!(sf || op[3:2] == 2'b10)) return old;
        if (is_arith(op)) return f;
        return {f[3:1], old[0]};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_srca, alu_srcb, alu_control, alu_carry_in, alu_shifter_carry);

    task automatic clear_reqs();
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req0_op = '0; req0_setflags = 0; req0_shc = 0;
        req1_a = '0; req1_b = '0; req1_op = '0; req1_setflags = 0; req1_shc = 0;
    endtask

    task automatic drive_req(input logic who, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, input logic sf, input logic shc);
        if (who) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; req1_setflags = sf; req1_shc = shc;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; req0_setflags = sf; req0_shc = shc;
        end
    endtask

    // One complete transaction from a single requester, checked at every phase
    task automatic run_op(input logic who, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic sf, input logic shc,
                          input int stall, input string tag);
        logic [35:0] exp;
        exp = alu_fn(a, b, op, flags_m[1], shc);
        @(negedge clk);
        drive_req(who, a, b, op, sf, shc);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== (who ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s accept: ready got %b expected %b", tag, {req1_ready, req0_ready}, who ? 2'b10 : 2'b01);
        end
        @(posedge clk);
        ptr_m = ~who;
        @(negedge clk);
        clear_reqs();
        #1;
        checks++;
        if ({rsp_valid, req1_ready, req0_ready, alu_srca, alu_srcb, alu_control, alu_carry_in, alu_shifter_carry}
            !== {3'b000, a, b, op, flags_m[1], shc}) begin
            errors++;
            $display("FAIL %s exec: valid/rdy=%b%b%b srca=%h srcb=%h ctl=%h cin=%b shc=%b expected 000 %h %h %h %b %b",
                     tag, rsp_valid, req1_ready, req0_ready, alu_srca, alu_srcb, alu_control, alu_carry_in,
                     alu_shifter_carry, a, b, op, flags_m[1], shc);
        end
        flags_m = next_flags(flags_m, exp[35:32], op, sf);
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_flags, alu_srca, alu_control} !== {1'b1, who, exp[31:0], exp[35:32], 32'd0, 4'd0}) begin
                errors++;
                $display("FAIL %s resp[%0d]: valid=%b id=%b result=%h rflags=%b srca=%h expected 1 %b %h %b 0",
                         tag, i, rsp_valid, rsp_id, rsp_result, rsp_flags, alu_srca, who, exp[31:0], exp[35:32]);
            end
        end
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if ({rsp_valid, flags} !== {1'b0, flags_m}) begin
            errors++;
            $display("FAIL %s done: valid=%b flags=%b expected 0 %b", tag, rsp_valid, flags, flags_m);
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        rsp_ready = 0;
        reset = 1;
        #2;
        req0_valid = 1;
        req1_valid = 1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags, flags, req0_ready, req1_ready,
             alu_srca, alu_srcb, alu_control, alu_carry_in, alu_shifter_carry} !== '0) begin
            errors++;
            $display("FAIL reset_state: rsp_valid=%b rdy=%b%b flags=%b srca=%h expected all zero",
                     rsp_valid, req1_ready, req0_ready, flags, alu_srca);
        end
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        reset = 0;
        ptr_m = 1'b0;
        flags_m = 4'b0000;
    endtask

    // Both requesters valid continuously: grants must alternate starting at requester 0
    task automatic test_round_robin();
        logic [31:0] ra [2], rb [2];
        logic [3:0]  rop [2];
        logic        rsf [2], rshc [2];
        logic [35:0] exp;
        logic        g;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ra[k] = $urandom; rb[k] = $urandom; rop[k] = 4'($urandom_range(0, 15));
                rsf[k] = 1'($urandom_range(0, 1)); rshc[k] = 1'($urandom_range(0, 1));
                drive_req(k[0], ra[k], rb[k], rop[k], rsf[k], rshc[k]);
            end
            g = i[0];
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: ready got %b expected %b", i, {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
            end
            exp = alu_fn(ra[g], rb[g], rop[g], flags_m[1], rshc[g]);
            @(posedge clk);
            ptr_m = ~g;
            @(negedge clk);
            checks++;
            if ({req1_ready, req0_ready, alu_srca, alu_control} !== {2'b00, ra[g], rop[g]}) begin
                errors++;
                $display("FAIL rr_exec[%0d]: rdy=%b%b srca=%h ctl=%h expected 00 %h %h",
                         i, req1_ready, req0_ready, alu_srca, alu_control, ra[g], rop[g]);
            end
            flags_m = next_flags(flags_m, exp[35:32], rop[g], rsf[g]);
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, req1_ready, req0_ready} !== {1'b1, g, exp[31:0], 2'b00}) begin
                errors++;
                $display("FAIL rr_resp[%0d]: valid=%b id=%b result=%h rdy=%b%b expected 1 %b %h 00",
                         i, rsp_valid, rsp_id, rsp_result, req1_ready, req0_ready, g, exp[31:0]);
            end
            rsp_ready = 1;
            @(posedge clk);
            #1;
            rsp_ready = 0;
        end
        @(negedge clk);
        clear_reqs();
        checks++;
        if (flags !== flags_m) begin
            errors++;
            $display("FAIL rr_flags: flags=%b expected %b", flags, flags_m);
        end
    endtask

    task automatic test_add_overflow();
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0100, 1'b1, 1'b0, 0, "add_ovf");
        checks++;
        if ({rsp_result, rsp_flags, flags} !== {32'h8000_0000, 4'b1001, 4'b1001}) begin
            errors++;
            $display("FAIL add_ovf_const: result=%h rflags=%b flags=%b expected 80000000 1001 1001",
                     rsp_result, rsp_flags, flags);
        end
    endtask

    task automatic test_carry_chain();
        run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0100, 1'b1, 1'b0, 0, "add_carry");
        checks++;
        if (flags !== 4'b0110) begin
            errors++;
            $display("FAIL add_carry_flags: flags=%b expected 0110", flags);
        end
        run_op(1'b0, 32'd2, 32'd3, 4'b0101, 1'b0, 1'b0, 0, "adc");
        checks++;
        if (rsp_result !== 32'd6) begin
            errors++;
            $display("FAIL adc_result: result=%h expected 00000006", rsp_result);
        end
    endtask

    // Response held for 5 cycles with both requesters pressing: payload stable, no accepts
    task automatic test_stall();
        logic [35:0] exp;
        logic        g;
        @(negedge clk);
        g = ptr_m;
        drive_req(1'b0, 32'h1234_5678, 32'h0000_0FFF, 4'b0010, 1'b0, 1'b0);
        drive_req(1'b1, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 4'b1100, 1'b0, 1'b1);
        exp = g ? alu_fn(32'hDEAD_BEEF, 32'h0F0F_0F0F, 4'b1100, flags_m[1], 1'b1)
                : alu_fn(32'h1234_5678, 32'h0000_0FFF, 4'b0010, flags_m[1], 1'b0);
        @(posedge clk);
        ptr_m = ~g;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_flags, req1_ready, req0_ready} !== {1'b1, g, exp[31:0], exp[35:32], 2'b00}) begin
                errors++;
                $display("FAIL stall[%0d]: valid=%b id=%b result=%h rflags=%b rdy=%b%b expected 1 %b %h %b 00",
                         i, rsp_valid, rsp_id, rsp_result, rsp_flags, req1_ready, req0_ready, g, exp[31:0], exp[35:32]);
            end
        end
        clear_reqs();
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_logical_flags();
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0100, 1'b1, 1'b0, 0, "set_v");
        run_op(1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b1000, 1'b0, 1'b1, 1, "tst");
        checks++;
        if (flags !== 4'b0111) begin
            errors++;
            $display("FAIL tst_flags: flags=%b expected 0111", flags);
        end
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0100, 1'b0, 1'b0, 0, "add_nosf");
        checks++;
        if (flags !== 4'b0111) begin
            errors++;
            $display("FAIL add_nosf_flags: flags=%b expected 0111", flags);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), "random");
        end
    endtask

    // Reset in the middle of EXEC: everything clears at once, no response afterwards
    task automatic test_reset_exec();
        @(negedge clk);
        drive_req(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0100, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        clear_reqs();
        #2;
        reset = 1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags, flags, req0_ready, req1_ready,
             alu_srca, alu_srcb, alu_control, alu_carry_in, alu_shifter_carry} !== '0) begin
            errors++;
            $display("FAIL reset_exec_async: rsp_valid=%b flags=%b srca=%h ctl=%h expected all zero",
                     rsp_valid, flags, alu_srca, alu_control);
        end
        @(negedge clk);
        reset = 0;
        ptr_m = 1'b0;
        flags_m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, flags} !== 5'b0) begin
                errors++;
                $display("FAIL reset_exec_after[%0d]: rsp_valid=%b flags=%b expected 0 0000", i, rsp_valid, flags);
            end
        end
        run_op(1'b1, 32'd10, 32'd20, 4'b0100, 1'b1, 1'b0, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_add_overflow();
        test_carry_chain();
        test_stall();
        test_logical_flags();
        test_random();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
